// File: rtl/keypad_event_fifo_ahb_if.sv
// AHB-Lite slave-side signal bundle for the keypad event FIFO.
// The master modport drives the address/data phase; the slave modport returns the response.
interface keypad_event_fifo_ahb_if;
   logic        HSEL;
   logic [11:0] HADDR;
   logic [1:0]  HTRANS;
   logic        HWRITE;
   logic [2:0]  HSIZE;
   logic [31:0] HWDATA;
   logic        HREADY;
   logic        HREADYOUT;
   logic        HRESP;
   logic [31:0] HRDATA;

   modport master (
      output HSEL, HADDR, HTRANS, HWRITE, HSIZE, HWDATA, HREADY,
      input  HREADYOUT, HRESP, HRDATA
   );

   modport slave (
      input  HSEL, HADDR, HTRANS, HWRITE, HSIZE, HWDATA, HREADY,
      output HREADYOUT, HRESP, HRDATA
   );
endinterface

// File: rtl/keypad_event_fifo_ahb.sv
// Keypad event FIFO behind a zero-wait-state AHB-Lite slave.
// Registers: DATA (pop on read), STATUS, CTRL (irq enable, overflow clear, flush).
module keypad_event_fifo_ahb #(
   parameter int DEPTH = 8
) (
   input  logic                          HCLK,
   input  logic                          HRESET,
   input  logic                          key_it,
   input  logic [3:0]                    key_val,
   keypad_event_fifo_ahb_if.slave        ahb,
   output logic                          irq
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

   typedef enum logic [1:0] {
      REG_DATA   = 2'd0,
      REG_STATUS = 2'd1,
      REG_CTRL   = 2'd2,
      REG_RSVD   = 2'd3
   } reg_e;

   logic [3:0]    mem_q [DEPTH];
   logic [3:0]    mem_d [DEPTH];
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] count_q, count_d;
   logic          ovf_q, ovf_d;
   logic          irq_en_q, irq_en_d;
   logic          dp_valid_q, dp_valid_d;
   logic          dp_write_q, dp_write_d;
   reg_e          dp_addr_q, dp_addr_d;

   logic          empty, full, rd_dp, pop, ctrl_wr, flush, push, ovf_set;
   logic [31:0]   hrdata;
   logic          unused_bits;

   assign empty   = (count_q == '0);
   assign full    = (count_q == FULL_CNT);
   assign rd_dp   = dp_valid_q & ~dp_write_q;
   assign pop     = rd_dp & (dp_addr_q == REG_DATA) & ~empty;
   assign ctrl_wr = dp_valid_q & dp_write_q & (dp_addr_q == REG_CTRL);
   assign flush   = ctrl_wr & ahb.HWDATA[2];
   // A pop in the same cycle frees the slot a push on a full FIFO needs.
   assign push    = key_it & ~flush & (~full | pop);
   assign ovf_set = key_it & ~flush & full & ~pop;

   always_comb begin
      // NOTE: every _d is given its hold value first, so no branch can leave it unassigned and infer a latch.
      mem_d      = mem_q;
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      count_d    = count_q;
      irq_en_d   = irq_en_q;
      ovf_d      = ovf_set | (ovf_q & ~(ctrl_wr & ahb.HWDATA[1]));
      dp_valid_d = ahb.HSEL & ahb.HTRANS[1] & ahb.HREADY;
      dp_write_d = ahb.HWRITE;
      dp_addr_d  = reg_e'(ahb.HADDR[3:2]);

      if (push) begin
         mem_d[wr_ptr_q] = key_val;
         wr_ptr_d        = wr_ptr_q + AW'(1);
      end
      if (pop) rd_ptr_d = rd_ptr_q + AW'(1);
      if (push && !pop)      count_d = count_q + CW'(1);
      else if (pop && !push) count_d = count_q - CW'(1);

      if (ctrl_wr) irq_en_d = ahb.HWDATA[0];
      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end
   end

   always_comb begin
      hrdata = '0;
      if (rd_dp) begin
         unique case (dp_addr_q)
            REG_DATA:   hrdata = empty ? 32'd0 : {23'd0, 1'b1, 4'd0, mem_q[rd_ptr_q]};
            REG_STATUS: hrdata = {23'd0, 5'(count_q), 1'b0, ovf_q, full, empty};
            REG_CTRL:   hrdata = {31'd0, irq_en_q};
            REG_RSVD:   hrdata = '0;
         endcase
      end
   end

   always_ff @(posedge HCLK) begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values regardless of statement order.
      if (HRESET) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         ovf_q      <= 1'b0;
         irq_en_q   <= 1'b0;
         dp_valid_q <= 1'b0;
         dp_write_q <= 1'b0;
         dp_addr_q  <= REG_DATA;
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         ovf_q      <= ovf_d;
         irq_en_q   <= irq_en_d;
         dp_valid_q <= dp_valid_d;
         dp_write_q <= dp_write_d;
         dp_addr_q  <= dp_addr_d;
      end
   end

   // NOTE: storage is not reset; count and pointers alone decide which entries are valid.
   always_ff @(posedge HCLK) begin
      mem_q <= mem_d;
   end

   assign ahb.HRDATA    = hrdata;
   assign ahb.HREADYOUT = 1'b1;
   assign ahb.HRESP     = 1'b0;
   assign irq           = irq_en_q & ~empty;

   assign unused_bits = ^{ahb.HSIZE, ahb.HADDR[11:4], ahb.HADDR[1:0], ahb.HTRANS[0],
                          ahb.HWDATA[31:3]};
endmodule
